// File: rtl/if_id_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_id_queue_pkg
//   Shared defaults and sizing helpers for the IF/ID instruction queue.
//   PC_W_DEF / INSTR_W_DEF : default field widths
//   NOP_INSTR_DEF          : instruction shown to decode while the queue is empty
//   count_w()              : occupancy counter width, able to hold 0..DEPTH
//   ptr_w()                : read/write pointer width (at least 1 bit)
// ---------------------------------------------------------------------------
package if_id_queue_pkg;

   localparam int          PC_W_DEF      = 64;
   localparam int          INSTR_W_DEF   = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A single-entry queue still needs a 1-bit pointer to index its array.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
//   Fetch-side and decode-side valid/ready bundle of the IF/ID queue.
//   in_valid/in_ready/in_pc/in_instr     : fetch -> queue
//   out_valid/out_ready/out_pc/out_instr : queue -> decode
//   slave  : the queue's view
//   master : the surrounding pipeline's view (fetch producer + decode consumer)
// ---------------------------------------------------------------------------
interface if_id_queue_if
   import if_id_queue_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
);

   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;

   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr
   );

   modport master (
      output in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr
   );

endinterface

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Small circular FIFO between instruction fetch and decode, replacing the
//   classic IF/ID pipeline register and its stall-write enable.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset (wins over flush)
//     q      : valid/ready bundle (slave modport), fetch in / decode out
//     flush  : drop every entry; beats push and pop in the same cycle
//     count  : current occupancy, 0..DEPTH
//   Outputs to decode come straight from the storage array at the read
//   pointer, so there is no in_* -> out_* combinational path. The only
//   combinational path is out_ready -> in_ready, which lets a full queue
//   (including DEPTH=1) accept a new entry in the same cycle decode drains one.
// ---------------------------------------------------------------------------
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int                 PC_W      = PC_W_DEF,
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter int                 DEPTH     = 2,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
)(
   input  logic                        clk,
   input  logic                        rst_n,
   if_id_queue_if.slave                q,
   input  logic                        flush,
   output logic [count_w(DEPTH)-1:0]   count
);

   localparam int CW = count_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("if_id_queue: DEPTH must be in 1..8");
   end

   // Storage holds data only; validity is tracked by count_q, so no reset.
   logic [PC_W-1:0]    pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];

   logic [PW-1:0] wptr_q,  wptr_d;
   logic [PW-1:0] rptr_q,  rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic not_full;
   logic push;
   logic pop;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      else                     return p + 1'b1;
   endfunction

   assign not_full   = (count_q < CW'(DEPTH));
   assign q.in_ready = not_full || q.out_ready;
   assign q.out_valid = (count_q != '0);

   assign push = q.in_valid  && q.in_ready  && !flush;
   assign pop  = q.out_valid && q.out_ready && !flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = ptr_inc(wptr_q);
         if (pop)  rptr_d = ptr_inc(rptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // When full with push+pop, wptr_q equals rptr_q's old slot only after the
   // head has moved on, so the write never clobbers the entry being read.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         pc_mem_q[wptr_q]    <= q.in_pc;
         instr_mem_q[wptr_q] <= q.in_instr;
      end
   end

   // Empty queue presents a harmless bubble to decode.
   assign q.out_pc    = q.out_valid ? pc_mem_q[rptr_q]    : '0;
   assign q.out_instr = q.out_valid ? instr_mem_q[rptr_q] : NOP_INSTR;
   assign count       = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
//   Drives a DEPTH=2 and a DEPTH=1 queue from the same stimulus. A queue-based
//   reference model per instance is compared against the DUT on every
//   falling edge; directed sequences add literal expectations, followed by a
//   randomized phase with occasional flush and reset.
// ---------------------------------------------------------------------------
module tb_if_id_queue;
   import if_id_queue_pkg::*;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_pc     = '0;
   logic [31:0] in_instr  = '0;

   logic [1:0]  count2;
   logic [0:0]  count1;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   if_id_queue_if ifc2();
   if_id_queue_if ifc1();

   assign ifc2.in_valid  = in_valid;
   assign ifc2.in_pc     = in_pc;
   assign ifc2.in_instr  = in_instr;
   assign ifc2.out_ready = out_ready;
   assign ifc1.in_valid  = in_valid;
   assign ifc1.in_pc     = in_pc;
   assign ifc1.in_instr  = in_instr;
   assign ifc1.out_ready = out_ready;

   if_id_queue #(.DEPTH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .q(ifc2), .flush(flush), .count(count2)
   );
   if_id_queue #(.DEPTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .q(ifc1), .flush(flush), .count(count1)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t m2[$];
   ent_t m1[$];

   always @(posedge clk) begin : model
      bit psh, pp;
      if (!rst_n || flush) begin
         m2.delete();
         m1.delete();
      end else begin
         pp  = (m2.size() != 0) && out_ready;
         psh = in_valid && ((m2.size() < 2) || out_ready);
         if (pp)  void'(m2.pop_front());
         if (psh) m2.push_back('{pc: in_pc, instr: in_instr});
         pp  = (m1.size() != 0) && out_ready;
         psh = in_valid && ((m1.size() < 1) || out_ready);
         if (pp)  void'(m1.pop_front());
         if (psh) m1.push_back('{pc: in_pc, instr: in_instr});
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("u2.count",     64'(count2), 64'(m2.size()));
         chk("u2.out_valid", 64'(ifc2.out_valid), 64'(m2.size() != 0));
         chk("u2.in_ready",  64'(ifc2.in_ready), 64'((m2.size() < 2) || out_ready));
         chk("u2.out_pc",    ifc2.out_pc, (m2.size() != 0) ? m2[0].pc : 64'h0);
         chk("u2.out_instr", 64'(ifc2.out_instr),
             (m2.size() != 0) ? 64'(m2[0].instr) : 64'h13);
         chk("u1.count",     64'(count1), 64'(m1.size()));
         chk("u1.out_valid", 64'(ifc1.out_valid), 64'(m1.size() != 0));
         chk("u1.in_ready",  64'(ifc1.in_ready), 64'((m1.size() < 1) || out_ready));
         chk("u1.out_pc",    ifc1.out_pc, (m1.size() != 0) ? m1[0].pc : 64'h0);
         chk("u1.out_instr", 64'(ifc1.out_instr),
             (m1.size() != 0) ? 64'(m1[0].instr) : 64'h13);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic summary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
   endtask

   initial begin
      #2000000;
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      summary();
      $finish;
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      rst_n = 1'b0;
      repeat (2) tick();
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst.count",     64'(count2), 64'd0);
      chk("rst.out_valid", 64'(ifc2.out_valid), 64'd0);
      chk("rst.out_pc",    ifc2.out_pc, 64'd0);
      chk("rst.out_instr", 64'(ifc2.out_instr), 64'h13);
      chk("rst.in_ready",  64'(ifc2.in_ready), 64'd1);

      // single push then immediate drain
      tick();
      rst_n = 1'b1; in_valid = 1'b1; in_pc = 64'h100; in_instr = 32'hAAAA0000; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat.out_valid", 64'(ifc2.out_valid), 64'd1);
      chk("lat.out_pc",    ifc2.out_pc, 64'h100);
      chk("lat.out_instr", 64'(ifc2.out_instr), 64'hAAAA0000);
      tick();
      @(negedge clk);
      chk("drain.out_valid", 64'(ifc2.out_valid), 64'd0);
      chk("drain.out_instr", 64'(ifc2.out_instr), 64'h13);

      // fill with decode stalled, third entry held
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h100;
      tick(); in_pc = 64'h104;
      tick(); in_pc = 64'h108;
      @(negedge clk);
      chk("full.count",    64'(count2), 64'd2);
      chk("full.in_ready", 64'(ifc2.in_ready), 64'd0);
      chk("full.out_pc",   ifc2.out_pc, 64'h100);
      tick();
      @(negedge clk);
      chk("stall.count",  64'(count2), 64'd2);
      chk("stall.out_pc", ifc2.out_pc, 64'h100);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("release.in_ready", 64'(ifc2.in_ready), 64'd1);
      chk("order.pc0",        ifc2.out_pc, 64'h100);
      tick(); in_valid = 1'b0;
      @(negedge clk);
      chk("order.pc1", ifc2.out_pc, 64'h104);
      tick();
      @(negedge clk);
      chk("order.pc2", ifc2.out_pc, 64'h108);
      chk("order.count", 64'(count2), 64'd1);
      tick();
      @(negedge clk);
      chk("order.empty", 64'(ifc2.out_valid), 64'd0);

      // full queue with simultaneous push and pop for 10 cycles
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h200;
      tick(); in_pc = 64'h204;
      tick(); out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_pc = 64'h208 + 64'(4 * k);
         @(negedge clk);
         chk("swap.count", 64'(count2), 64'd2);
         chk("swap.head",  ifc2.out_pc, 64'h200 + 64'(4 * k));
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("swap.tail0", ifc2.out_pc, 64'h228);
      tick();
      @(negedge clk);
      chk("swap.tail1", ifc2.out_pc, 64'h22C);
      tick();

      // flush beats push and pop
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h300;
      tick(); in_pc = 64'h304;
      tick(); flush = 1'b1; in_pc = 64'h308; out_ready = 1'b1;
      @(negedge clk);
      chk("preflush.count", 64'(count2), 64'd2);
      tick(); flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush.count",     64'(count2), 64'd0);
      chk("flush.out_valid", 64'(ifc2.out_valid), 64'd0);
      chk("flush.out_instr", 64'(ifc2.out_instr), 64'h13);
      tick();
      @(negedge clk);
      chk("flush.nostore", 64'(count2), 64'd0);

      // reset mid-operation
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h400; in_instr = 32'h1234_5678;
      tick(); in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("prerst.count", 64'(count2), 64'd1);
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("midrst.count",     64'(count2), 64'd0);
      chk("midrst.out_pc",    ifc2.out_pc, 64'd0);
      chk("midrst.out_instr", 64'(ifc2.out_instr), 64'h13);

      // DEPTH=1 streaming: one entry per cycle, no bubbles
      out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_pc = 64'h500 + 64'(4 * k);
         @(negedge clk);
         chk("d1.in_ready", 64'(ifc1.in_ready), 64'd1);
         if (k > 0) begin
            chk("d1.out_valid", 64'(ifc1.out_valid), 64'd1);
            chk("d1.out_pc",    ifc1.out_pc, 64'h500 + 64'(4 * (k - 1)));
         end
         tick();
      end
      in_valid = 1'b0;
      tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst_n     = ($urandom_range(0, 63) != 0);
         in_pc     = {32'($urandom), 32'($urandom)};
         in_instr  = 32'($urandom);
         tick();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      #1;
      summary();
      $finish;
   end

endmodule
